// File: rtl/proc_pkg.sv
// Shared constants for the lab-processor control path: opcodes, ALU selects,
// state encoding and instruction field positions.
package proc_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD_A = 4'd3,
    ST_LOAD_B = 4'd4,
    ST_STORE  = 4'd5,
    ST_ADD    = 4'd6,
    ST_SUB    = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

  // The data address overlaps both source-register fields.
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RA_MSB    = 11;
  localparam int RA_LSB    = 8;
  localparam int RB_MSB    = 7;
  localparam int RB_LSB    = 4;
  localparam int RD_MSB    = 3;
  localparam int RD_LSB    = 0;
  localparam int DADDR_MSB = 11;
  localparam int DADDR_LSB = 4;

endpackage

// File: rtl/pc_ir_reg.sv
// Program counter and instruction register; both advance only on a fetch.
module pc_ir_reg #(
  parameter int PC_W = 7,
  parameter int I_W  = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            ld,
  input  logic [I_W-1:0]  IM_data,
  output logic [PC_W-1:0] PC,
  output logic [I_W-1:0]  IR
);

  // Capture the fetched word and step the PC; the add wraps modulo 2^PC_W.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      PC <= {PC_W{1'b0}};
      IR <= {I_W{1'b0}};
    end else if (ld) begin
      PC <= PC + PC_W'(1);
      IR <= IM_data;
    end else begin
      PC <= PC;
      IR <= IR;
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multicycle Moore control unit: FETCH, DECODE, then one or two execute
// states per instruction, driving memories, register file and ALU select.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int D_AW = 8,
  parameter int I_W  = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [I_W-1:0]  IM_data,
  output logic [PC_W-1:0] IM_addr,
  output logic            IM_rd,
  output logic [D_AW-1:0] D_addr,
  output logic            D_rd,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic            RF_Ra_en,
  output logic [3:0]      RF_Rb_addr,
  output logic            RF_Rb_en,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      State
);

  state_t          state_r;
  logic            ld_s;
  logic [PC_W-1:0] pc_s;
  logic [I_W-1:0]  ir_s;
  logic [3:0]      opcode_s;
  logic [3:0]      ra_s;
  logic [3:0]      rb_s;
  logic [3:0]      rd_s;
  logic [D_AW-1:0] daddr_s;

  assign ld_s     = (state_r == ST_FETCH);
  assign opcode_s = ir_s[OPC_MSB:OPC_LSB];
  assign ra_s     = ir_s[RA_MSB:RA_LSB];
  assign rb_s     = ir_s[RB_MSB:RB_LSB];
  assign rd_s     = ir_s[RD_MSB:RD_LSB];
  assign daddr_s  = D_AW'(ir_s[DADDR_MSB:DADDR_LSB]);
  assign State    = state_r;

  pc_ir_reg #(.PC_W(PC_W), .I_W(I_W)) u_pc_ir (
    .Clk     (Clk),
    .Rst     (Rst),
    .ld      (ld_s),
    .IM_data (IM_data),
    .PC      (pc_s),
    .IR      (ir_s)
  );

  // State sequencing; reset wins over every transition, HALT included.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_INIT;
    end else begin
      case (state_r)
        ST_INIT:   state_r <= ST_FETCH;
        ST_FETCH:  state_r <= ST_DECODE;
        ST_DECODE: begin
          case (opcode_s)
            OP_LOAD:  state_r <= ST_LOAD_A;
            OP_STORE: state_r <= ST_STORE;
            OP_ADD:   state_r <= ST_ADD;
            OP_SUB:   state_r <= ST_SUB;
            OP_HALT:  state_r <= ST_HALT;
            default:  state_r <= ST_FETCH;
          endcase
        end
        ST_LOAD_A: state_r <= ST_LOAD_B;
        ST_LOAD_B: state_r <= ST_FETCH;
        ST_STORE:  state_r <= ST_FETCH;
        ST_ADD:    state_r <= ST_FETCH;
        ST_SUB:    state_r <= ST_FETCH;
        ST_HALT:   state_r <= ST_HALT;
        default:   state_r <= ST_INIT;
      endcase
    end
  end

  // Moore output decode: everything idles at zero unless the state drives it.
  always_comb begin
    IM_addr    = {PC_W{1'b0}};
    IM_rd      = 1'b0;
    D_addr     = {D_AW{1'b0}};
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Ra_en   = 1'b0;
    RF_Rb_addr = 4'd0;
    RF_Rb_en   = 1'b0;
    ALU_s0     = ALU_PASS;
    case (state_r)
      ST_FETCH: begin
        IM_rd   = 1'b1;
        IM_addr = pc_s;
      end
      ST_LOAD_A: begin
        D_addr = daddr_s;
        D_rd   = 1'b1;
      end
      ST_LOAD_B: begin
        D_addr    = daddr_s;
        RF_s      = 1'b1;
        RF_W_addr = rd_s;
        RF_W_en   = 1'b1;
      end
      ST_STORE: begin
        D_addr     = daddr_s;
        RF_Ra_addr = rd_s;
        RF_Ra_en   = 1'b1;
        D_wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_addr = ra_s;
        RF_Ra_en   = 1'b1;
        RF_Rb_addr = rb_s;
        RF_Rb_en   = 1'b1;
        ALU_s0     = (state_r == ST_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_addr  = rd_s;
        RF_W_en    = 1'b1;
      end
      default: begin
        IM_rd = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench: cycle-by-cycle vector table over a short program, plus a
// NOOP sweep that checks PC wrap from 127 back to 0.
module tb_proc_control_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] IM_data;
  logic [6:0]  IM_addr;
  logic        IM_rd;
  logic [7:0]  D_addr;
  logic        D_rd, D_wr, RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic        RF_Ra_en;
  logic [3:0]  RF_Rb_addr;
  logic        RF_Rb_en;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;

  logic [15:0] im [128];
  logic [40:0] obs;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [40:0] exp;
    logic        chk_pc;
    logic [6:0]  pc;
  } vec_t;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  assign IM_data = im[IM_addr];
  assign obs = {State, IM_rd, IM_addr, D_addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Ra_en, RF_Rb_addr, RF_Rb_en, ALU_s0};

  proc_control_unit dut (
    .Clk(Clk), .Rst(Rst), .IM_data(IM_data), .IM_addr(IM_addr), .IM_rd(IM_rd),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Ra_en(RF_Ra_en),
    .RF_Rb_addr(RF_Rb_addr), .RF_Rb_en(RF_Rb_en),
    .ALU_s0(ALU_s0), .State(State)
  );

  function automatic logic [40:0] ev(input logic [3:0] st, input logic imrd, input logic [6:0] ima,
                                     input logic [7:0] da, input logic drd, input logic dwr,
                                     input logic rfs, input logic [3:0] wa, input logic wen,
                                     input logic [3:0] ra, input logic raen,
                                     input logic [3:0] rb, input logic rben, input logic [2:0] alu);
    return {st, imrd, ima, da, drd, dwr, rfs, wa, wen, ra, raen, rb, rben, alu};
  endfunction

  function automatic logic [40:0] idle(input logic [3:0] st);
    return ev(st, 1'b0, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0);
  endfunction

  function automatic logic [40:0] fetch(input logic [6:0] a);
    return ev(4'd1, 1'b1, a, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0);
  endfunction

  task automatic push(input logic r, input logic [40:0] e, input logic cp, input logic [6:0] p);
    vec_t v;
    v.rst = r; v.exp = e; v.chk_pc = cp; v.pc = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) im[i] = 16'h0000;
    im[0] = 16'h21B3;  // LOAD r3 <- D[0x1B]
    im[1] = 16'h3335;  // ADD r5 = r3 + r3
    im[2] = 16'h1405;  // STORE D[0x40] <- r5
    im[3] = 16'h4729;  // SUB r9 = r7 - r2
    im[4] = 16'hA123;  // undefined, runs as NOOP
    im[5] = 16'h5000;  // HALT
    Rst = 1'b1;

    push(1'b1, idle(4'd0), 1'b1, 7'd0);
    push(1'b1, idle(4'd0), 1'b1, 7'd0);
    push(1'b0, fetch(7'd0), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    push(1'b0, ev(4'd3, 1'b0, 7'd0, 8'h1B, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0), 1'b0, 7'd0);
    push(1'b0, ev(4'd4, 1'b0, 7'd0, 8'h1B, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0), 1'b0, 7'd0);
    push(1'b0, fetch(7'd1), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    push(1'b0, ev(4'd6, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 3'd1), 1'b0, 7'd0);
    push(1'b0, fetch(7'd2), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    push(1'b0, ev(4'd5, 1'b0, 7'd0, 8'h40, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 3'd0), 1'b0, 7'd0);
    push(1'b0, fetch(7'd3), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    push(1'b0, ev(4'd7, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 3'd2), 1'b0, 7'd0);
    push(1'b0, fetch(7'd4), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    push(1'b0, fetch(7'd5), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    for (int i = 0; i < 10; i++) push(1'b0, idle(4'd8), 1'b1, 7'd6);
    push(1'b1, idle(4'd0), 1'b1, 7'd0);
    push(1'b0, fetch(7'd0), 1'b0, 7'd0);
    push(1'b0, idle(4'd2), 1'b0, 7'd0);
    push(1'b0, ev(4'd3, 1'b0, 7'd0, 8'h1B, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0), 1'b0, 7'd0);
    push(1'b1, idle(4'd0), 1'b1, 7'd0);
    push(1'b0, fetch(7'd0), 1'b0, 7'd0);

    foreach (vecs[i]) begin
      Rst = vecs[i].rst;
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
      if (vecs[i].chk_pc) begin
        check($sformatf("vec%0d_pc", i), 41'(dut.pc_s), 41'(vecs[i].pc));
      end
    end

    // NOOP sweep: PC advances once per two cycles and wraps after 127.
    for (int i = 0; i < 128; i++) im[i] = 16'h0000;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int k = 0; k < 130; k++) begin
      @(posedge Clk);
      #1;
      check($sformatf("wrap_fetch%0d", k), obs, fetch(7'(k % 128)));
      @(posedge Clk);
      #1;
      check($sformatf("wrap_decode%0d", k), obs, idle(4'd2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
